// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: pin synchroniser, 11-bit frame deserialiser with
// start/parity/stop/timeout checking, and a show-ahead scan-code FIFO.
module ps2_rx_fifo #(
    parameter int WORD_SIZE      = 64,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int CNT_W          = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 kbdClk,
    input  logic                 kbdDataIn,
    output logic [WORD_SIZE-1:0] dataOut,
    output logic                 dataValid,
    input  logic                 dataReady,
    output logic [CNT_W-1:0]     count,
    output logic                 overflow,
    input  logic                 clrOverflow,
    output logic                 frameErr,
    output logic [1:0]           dbgState
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rxStateT;

    // ---------------- pin synchroniser ----------------
    logic [1:0] clkSyncQ;
    logic [1:0] dataSyncQ;
    logic       clkPrev;
    logic       fallEdge;
    logic       bitIn;

    // Flops reset to the idle bus level so release never looks like an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clkSyncQ  <= 2'b11;
            dataSyncQ <= 2'b11;
            clkPrev   <= 1'b1;
        end else begin
            clkSyncQ  <= {clkSyncQ[0], kbdClk};
            dataSyncQ <= {dataSyncQ[0], kbdDataIn};
            clkPrev   <= clkSyncQ[1];
        end
    end

    assign fallEdge = clkPrev & ~clkSyncQ[1];
    assign bitIn    = dataSyncQ[1];

    // ---------------- frame FSM ----------------
    rxStateT        state, stateN;
    logic [2:0]     bitCnt, bitCntN;
    logic [7:0]     shiftQ, shiftN;
    logic           parityQ, parityN;
    logic [TO_W-1:0] toCnt, toCntN;
    logic           pushReq;
    logic           errDet;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            bitCnt   <= '0;
            shiftQ   <= '0;
            parityQ  <= 1'b0;
            toCnt    <= '0;
            frameErr <= 1'b0;
        end else begin
            state    <= stateN;
            bitCnt   <= bitCntN;
            shiftQ   <= shiftN;
            parityQ  <= parityN;
            toCnt    <= toCntN;
            frameErr <= errDet;
        end
    end

    always_comb begin
        stateN  = state;
        bitCntN = bitCnt;
        shiftN  = shiftQ;
        parityN = parityQ;
        toCntN  = toCnt;
        pushReq = 1'b0;
        errDet  = 1'b0;
        if (state != IDLE) begin
            toCntN = toCnt + 1'b1;
        end
        if (fallEdge) begin
            toCntN = '0;
            case (state)
                IDLE: begin
                    if (!bitIn) begin
                        stateN  = DATA;
                        bitCntN = '0;
                        shiftN  = '0;
                    end else begin
                        errDet = 1'b1;
                    end
                end
                DATA: begin
                    shiftN  = {bitIn, shiftQ[7:1]};
                    bitCntN = bitCnt + 1'b1;
                    if (bitCnt == 3'd7) begin
                        stateN = PARITY;
                    end
                end
                PARITY: begin
                    parityN = bitIn;
                    stateN  = STOP;
                end
                STOP: begin
                    // Odd parity over data plus parity bit, and a high stop bit.
                    if (bitIn && ((^shiftQ) ^ parityQ)) begin
                        pushReq = 1'b1;
                    end else begin
                        errDet = 1'b1;
                    end
                    stateN = IDLE;
                end
                default: stateN = IDLE;
            endcase
        end else if (state != IDLE && toCnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            stateN = IDLE;
            toCntN = '0;
            errDet = 1'b1;
        end
    end

    assign dbgState = state;

    // ---------------- scan-code FIFO ----------------
    // Handshake: dataValid is high whenever the FIFO holds a byte and dataOut is
    // the head; the head is consumed on any rising edge with dataValid && dataReady.
    // dataValid never depends on dataReady, and dataOut is zero while empty.
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic [CNT_W-1:0] cnt;
    logic             full;
    logic             doPop;
    logic             doPush;
    logic             drop;

    assign full      = (cnt == CNT_W'(FIFO_DEPTH));
    assign dataValid = (cnt != '0);
    assign doPop     = dataValid & dataReady;
    assign doPush    = pushReq & (~full | doPop);
    assign drop      = pushReq & full & ~doPop;

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= shiftQ;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdPtr    <= '0;
            wrPtr    <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            // A new drop outranks a clear requested in the same cycle.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clrOverflow) begin
                overflow <= 1'b0;
            end
        end
    end

    assign count   = cnt;
    assign dataOut = dataValid ? {{(WORD_SIZE - 8){1'b0}}, mem[rdPtr]} : '0;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: frame table plus hand sequences for overflow,
// full-FIFO push/pop, timeout and mid-frame reset.
module tb_ps2_rx_fifo;

    localparam int WORD_SIZE      = 64;
    localparam int FIFO_DEPTH     = 8;
    localparam int TIMEOUT_CYCLES = 5000;
    localparam int CNT_W          = 4;

    logic                 clk;
    logic                 rst;
    logic                 kbdClk;
    logic                 kbdDataIn;
    logic [WORD_SIZE-1:0] dataOut;
    logic                 dataValid;
    logic                 dataReady;
    logic [CNT_W-1:0]     count;
    logic                 overflow;
    logic                 clrOverflow;
    logic                 frameErr;
    logic [1:0]           dbgState;

    ps2_rx_fifo #(
        .WORD_SIZE     (WORD_SIZE),
        .FIFO_DEPTH    (FIFO_DEPTH),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .kbdClk     (kbdClk),
        .kbdDataIn  (kbdDataIn),
        .dataOut    (dataOut),
        .dataValid  (dataValid),
        .dataReady  (dataReady),
        .count      (count),
        .overflow   (overflow),
        .clrOverflow(clrOverflow),
        .frameErr   (frameErr),
        .dbgState   (dbgState)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks    = 0;
    int errors    = 0;
    int errPulses = 0;

    logic [7:0] expQ[$];

    always @(negedge clk) begin
        if (rst === 1'b1 && frameErr === 1'b1) errPulses++;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- PS/2 driver ----------------
    function automatic logic [10:0] mkFrame(input logic [7:0] d, input logic parFlip,
                                            input logic stopBit);
        return {stopBit, (~(^d)) ^ parFlip, d, 1'b0};
    endfunction

    // Returns on the negedge where kbdClk has just been driven low.
    task automatic ps2Fall(input logic b);
        @(negedge clk);
        kbdDataIn = b;
        repeat (3) @(negedge clk);
        kbdClk = 1'b0;
    endtask

    task automatic ps2Rise();
        repeat (4) @(negedge clk);
        kbdClk = 1'b1;
    endtask

    task automatic sendHead(input logic [10:0] f);
        for (int i = 0; i < 11; i++) begin
            ps2Fall(f[i]);
            if (i < 10) ps2Rise();
        end
    endtask

    task automatic sendFrame(input logic [10:0] f);
        sendHead(f);
        ps2Rise();
    endtask

    // Pops every expected byte in order, then requires an empty FIFO.
    task automatic drainCheck(input string nm);
        logic [7:0] e;
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            check({nm, "Valid"}, {63'd0, dataValid}, 64'd1);
            check({nm, "Head"}, dataOut, {56'd0, e});
            dataReady = 1'b1;
            @(negedge clk);
        end
        dataReady = 1'b0;
        check({nm, "Empty"}, {63'd0, dataValid}, 64'd0);
        check({nm, "EmptyData"}, dataOut, 64'd0);
    endtask

    // ---------------- frame table ----------------
    typedef struct {
        logic [7:0] d;
        logic       parFlip;
        logic       stopBit;
        logic       expPush;
        logic       expErr;
    } vecT;

    vecT vecs[7];

    initial begin
        int errBase;
        int first;

        vecs[0] = '{d: 8'h1C, parFlip: 1'b0, stopBit: 1'b1, expPush: 1'b1, expErr: 1'b0};
        vecs[1] = '{d: 8'h1C, parFlip: 1'b1, stopBit: 1'b1, expPush: 1'b0, expErr: 1'b1};
        vecs[2] = '{d: 8'h5A, parFlip: 1'b0, stopBit: 1'b1, expPush: 1'b1, expErr: 1'b0};
        vecs[3] = '{d: 8'h00, parFlip: 1'b0, stopBit: 1'b1, expPush: 1'b1, expErr: 1'b0};
        vecs[4] = '{d: 8'hFF, parFlip: 1'b0, stopBit: 1'b1, expPush: 1'b1, expErr: 1'b0};
        vecs[5] = '{d: 8'hA5, parFlip: 1'b0, stopBit: 1'b0, expPush: 1'b0, expErr: 1'b1};
        vecs[6] = '{d: 8'h80, parFlip: 1'b1, stopBit: 1'b1, expPush: 1'b0, expErr: 1'b1};

        // ---------------- reset ----------------
        rst         = 1'b0;
        kbdClk      = 1'b1;
        kbdDataIn   = 1'b1;
        dataReady   = 1'b0;
        clrOverflow = 1'b0;
        repeat (3) @(negedge clk);
        check("rstValid", {63'd0, dataValid}, 64'd0);
        check("rstData", dataOut, 64'd0);
        check("rstCount", {60'd0, count}, 64'd0);
        check("rstOverflow", {63'd0, overflow}, 64'd0);
        check("rstFrameErr", {63'd0, frameErr}, 64'd0);
        check("rstState", {62'd0, dbgState}, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // ---------------- table: good and bad frames ----------------
        for (int i = 0; i < 7; i++) begin
            dataReady = 1'b0;
            sendHead(mkFrame(vecs[i].d, vecs[i].parFlip, vecs[i].stopBit));
            repeat (2) @(negedge clk);
            check("vecNotEarly", {63'd0, dataValid}, 64'd0);
            check("vecErrNotEarly", {63'd0, frameErr}, 64'd0);
            @(negedge clk);
            check("vecValid", {63'd0, dataValid}, {63'd0, vecs[i].expPush});
            check("vecData", dataOut, vecs[i].expPush ? {56'd0, vecs[i].d} : 64'd0);
            check("vecCount", {60'd0, count}, {63'd0, vecs[i].expPush});
            check("vecErr", {63'd0, frameErr}, {63'd0, vecs[i].expErr});
            @(negedge clk);
            check("vecErrOneCycle", {63'd0, frameErr}, 64'd0);
            ps2Rise();
            if (vecs[i].expPush) begin
                dataReady = 1'b1;
                @(negedge clk);
                dataReady = 1'b0;
            end
            check("vecDrained", {60'd0, count}, 64'd0);
        end

        // ---------------- overflow: 9 frames into 8 slots ----------------
        dataReady = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            sendFrame(mkFrame(8'(k), 1'b0, 1'b1));
            if (k <= 8) expQ.push_back(8'(k));
            if (k == 8) check("ovfNotYet", {63'd0, overflow}, 64'd0);
        end
        check("ovfCount", {60'd0, count}, 64'd8);
        check("ovfSet", {63'd0, overflow}, 64'd1);
        drainCheck("ovfDrain");
        check("ovfSticky", {63'd0, overflow}, 64'd1);
        clrOverflow = 1'b1;
        @(negedge clk);
        clrOverflow = 1'b0;
        check("ovfCleared", {63'd0, overflow}, 64'd0);

        // ---------------- full FIFO, push and pop in the same cycle ----------------
        for (int k = 0; k < 8; k++) begin
            sendFrame(mkFrame(8'h11 + 8'(k), 1'b0, 1'b1));
            expQ.push_back(8'h11 + 8'(k));
        end
        check("fullCount", {60'd0, count}, 64'd8);
        sendHead(mkFrame(8'h77, 1'b0, 1'b1));
        repeat (2) @(negedge clk);
        dataReady = 1'b1;
        @(negedge clk);
        dataReady = 1'b0;
        void'(expQ.pop_front());
        expQ.push_back(8'h77);
        check("pushPopCount", {60'd0, count}, 64'd8);
        check("pushPopNoOvf", {63'd0, overflow}, 64'd0);
        check("pushPopHead", dataOut, 64'h12);
        ps2Rise();
        drainCheck("pushPopDrain");

        // ---------------- timeout mid-frame ----------------
        errBase = errPulses;
        first   = 0;
        for (int i = 0; i < 5; i++) begin
            ps2Fall((i == 0) ? 1'b0 : 1'b1);
            if (i < 4) ps2Rise();
        end
        for (int n = 1; n <= TIMEOUT_CYCLES + 20; n++) begin
            @(negedge clk);
            if (n == 4) kbdClk = 1'b1;
            if (frameErr === 1'b1 && first == 0) first = n;
        end
        check("toPulses", 64'(errPulses - errBase), 64'd1);
        check("toLatency", {63'd0, (first >= TIMEOUT_CYCLES + 1) && (first <= TIMEOUT_CYCLES + 5)},
              64'd1);
        check("toIdle", {62'd0, dbgState}, 64'd0);
        check("toNoPush", {60'd0, count}, 64'd0);
        sendFrame(mkFrame(8'h29, 1'b0, 1'b1));
        check("toNextData", dataOut, 64'h29);
        check("toNextCount", {60'd0, count}, 64'd1);
        check("toNextNoErr", 64'(errPulses - errBase), 64'd1);

        // ---------------- reset in the middle of a frame ----------------
        for (int i = 0; i < 5; i++) begin
            ps2Fall((i == 0) ? 1'b0 : 1'b0);
            ps2Rise();
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midRstValid", {63'd0, dataValid}, 64'd0);
        check("midRstData", dataOut, 64'd0);
        check("midRstCount", {60'd0, count}, 64'd0);
        check("midRstOverflow", {63'd0, overflow}, 64'd0);
        check("midRstFrameErr", {63'd0, frameErr}, 64'd0);
        kbdClk = 1'b0;
        @(negedge clk);
        kbdClk = 1'b1;
        repeat (2) @(negedge clk);
        rst     = 1'b1;
        errBase = errPulses;
        @(negedge clk);
        check("postRstState", {62'd0, dbgState}, 64'd0);
        sendFrame(mkFrame(8'h12, 1'b0, 1'b1));
        check("postRstData", dataOut, 64'h12);
        check("postRstCount", {60'd0, count}, 64'd1);
        check("postRstNoErr", 64'(errPulses - errBase), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
